// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB master port between NUM_REQ requesters.
// Each grant becomes a single NONSEQ transfer; the response returns to its owner.
module ahb_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          HSEL,
    output logic [ADDR_WIDTH-1:0]         HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic                          HREADY_IN,
    output logic [DATA_WIDTH-1:0]         HWDATA,
    input  logic [DATA_WIDTH-1:0]         HRDATA,
    input  logic [1:0]                    HRESP,
    input  logic                          HREADY_OUT
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = ID_W + 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] owner_q;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic [CW-1:0]   cand;
    logic            grant;
    logic            addr_done;
    logic            data_done;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search from rr+1 upward; walking k downward lets the nearest candidate win last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant_found = 1'b0;
        grant_id    = rr_q;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, rr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    assign grant     = (state_q == IDLE) && grant_found;
    assign addr_done = (state_q == ADDR) && HREADY_OUT;
    assign data_done = (state_q == DATA) && HREADY_OUT;
    assign HREADY_IN = HREADY_OUT;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = ADDR;
                    // The accept pulse must stay low while reset is held.
                    req_ready[grant_id] = HRESETn;
                end
            end
            ADDR: begin
                if (HREADY_OUT) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (HREADY_OUT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rr_q      <= ID_W'(NUM_REQ - 1);
            owner_q   <= '0;
            HSEL      <= 1'b0;
            HTRANS    <= HTRANS_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;

            if (grant) begin
                owner_q <= grant_id;
                rr_q    <= grant_id;
                HSEL    <= 1'b1;
                HTRANS  <= HTRANS_NONSEQ;
                HADDR   <= addr_arr[grant_id];
                HWRITE  <= req_write[grant_id];
                HWDATA  <= wdata_arr[grant_id];
            end

            // Address-phase outputs only drop once the slave accepts the address.
            if (addr_done) begin
                HSEL   <= 1'b0;
                HTRANS <= HTRANS_IDLE;
            end

            if (data_done) begin
                rsp_valid[owner_q] <= 1'b1;
                rsp_rdata          <= HWRITE ? '0 : HRDATA;
                rsp_err            <= (HRESP != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Randomised bench for ahb_master_arbiter: a transaction-level slave schedule and a
// round-robin reference predict every output cycle by cycle.
module tb_ahb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 2;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            HSEL;
    logic [AW-1:0]   HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic            HREADY_IN;
    logic [DW-1:0]   HWDATA;
    logic [DW-1:0]   HRDATA;
    logic [1:0]      HRESP;
    logic            HREADY_OUT;

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_REQ   (N)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY_IN (HREADY_IN),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .HREADY_OUT(HREADY_OUT)
    );

    typedef enum int {GEN_MANUAL, GEN_RANDOM, GEN_HOLD} gen_mode_t;

    // One granted transfer described by its grant cycle and wait-state counts.
    typedef struct {
        bit            act;
        int            g;
        int            aw;
        int            dw;
        int            owner;
        bit            err;
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } xfer_t;

    int            n_vec  = 0;
    int            n_miss = 0;
    int            t      = 0;
    gen_mode_t     mode;
    logic          pend    [N];
    logic [AW-1:0] p_addr  [N];
    logic [DW-1:0] p_wdata [N];
    logic          p_write [N];
    xfer_t         cur;
    int            last_w;
    logic [DW-1:0] hwdata_exp;
    bit            use_fix;
    int            fix_aw;
    int            fix_dw;
    bit            fix_err;
    logic [DW-1:0] fix_rdata;
    int            grant_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic new_req(input int i, input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] d);
        pend[i]    = 1'b1;
        p_addr[i]  = a;
        p_write[i] = w;
        p_wdata[i] = d;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pend[i];
            req_write[i]            = p_write[i];
            req_addr[i*AW +: AW]    = p_addr[i];
            req_wdata[i*DW +: DW]   = p_wdata[i];
        end
    endtask

    function automatic int rr_pick(input int last);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit busy();
        return cur.act && ((t - cur.g) <= 3 + cur.aw + cur.dw);
    endfunction

    task automatic step();
        int           o;
        int           w;
        bit           in_addr;
        bit           in_data;
        bit           in_rsp;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;

        @(negedge HCLK);
        HRESETn = 1'b1;
        case (mode)
            GEN_RANDOM: begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) begin
                        if ($urandom_range(15) == 0) pend[i] = 1'b0;
                    end else if ($urandom_range(2) == 0) begin
                        new_req(i, $urandom, ($urandom_range(1) == 1), $urandom);
                    end
                end
            end
            GEN_HOLD: begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i]) new_req(i, $urandom, ($urandom_range(1) == 1), $urandom);
                end
            end
            default: ;
        endcase
        drive_reqs();

        o       = t - cur.g;
        in_addr = cur.act && (o >= 1) && (o <= 1 + cur.aw);
        in_data = cur.act && (o >= 2 + cur.aw) && (o <= 2 + cur.aw + cur.dw);
        in_rsp  = cur.act && (o == 3 + cur.aw + cur.dw);

        HRESP      = 2'b00;
        HRDATA     = $urandom;
        HREADY_OUT = ($urandom_range(1) == 1);
        if (in_addr) begin
            HREADY_OUT = (o == 1 + cur.aw);
        end else if (in_data) begin
            HREADY_OUT = (o == 2 + cur.aw + cur.dw);
            if (cur.err && (o >= 1 + cur.aw + cur.dw)) HRESP = 2'b01;
            if (HREADY_OUT) HRDATA = cur.rdata;
        end

        w         = (!in_addr && !in_data) ? rr_pick(last_w) : -1;
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        exp_rsp = '0;
        if (in_rsp) exp_rsp[cur.owner] = 1'b1;

        #1;
        check("req_ready", req_ready, exp_ready);
        check("HSEL", HSEL, in_addr);
        check("HTRANS", HTRANS, in_addr ? 2'b10 : 2'b00);
        if (in_addr) begin
            check("HADDR", HADDR, cur.addr);
            check("HWRITE", HWRITE, cur.write);
        end
        check("HWDATA", HWDATA, hwdata_exp);
        check("HREADY_IN", HREADY_IN, HREADY_OUT);
        check("rsp_valid", rsp_valid, exp_rsp);
        if (in_rsp) begin
            check("rsp_rdata", rsp_rdata, cur.write ? '0 : cur.rdata);
            check("rsp_err", rsp_err, cur.err);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) grant_log.push_back(i);
        end

        @(posedge HCLK);
        if (w >= 0) begin
            cur.act   = 1'b1;
            cur.g     = t;
            cur.owner = w;
            cur.write = p_write[w];
            cur.addr  = p_addr[w];
            cur.wdata = p_wdata[w];
            if (use_fix) begin
                cur.aw    = fix_aw;
                cur.dw    = fix_dw;
                cur.err   = fix_err;
                cur.rdata = fix_rdata;
            end else begin
                cur.aw    = int'($urandom_range(2));
                cur.dw    = int'($urandom_range(3));
                cur.err   = ($urandom_range(4) == 0);
                cur.rdata = $urandom;
            end
            if (cur.err && cur.dw == 0) cur.dw = 1;
            hwdata_exp = cur.wdata;
            last_w     = w;
            pend[w]    = 1'b0;
        end
        t++;
    endtask

    task automatic apply_reset();
        @(negedge HCLK);
        HRESETn    = 1'b0;
        drive_reqs();
        HRESP      = 2'b00;
        HREADY_OUT = 1'b1;
        cur.act    = 1'b0;
        last_w     = N - 1;
        hwdata_exp = '0;
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_HSEL", HSEL, 1'b0);
        check("rst_HTRANS", HTRANS, 2'b00);
        check("rst_HADDR", HADDR, '0);
        check("rst_HWRITE", HWRITE, 1'b0);
        check("rst_HWDATA", HWDATA, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        repeat (2) begin
            @(posedge HCLK);
            t++;
        end
    endtask

    task automatic run_xfer();
        step();
        while (busy()) step();
    endtask

    task automatic drain();
        mode = GEN_MANUAL;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        while (busy()) step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        HRESETn    = 1'b0;
        HRDATA     = '0;
        HRESP      = 2'b00;
        HREADY_OUT = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mode       = GEN_MANUAL;
        use_fix    = 1'b1;
        fix_err    = 1'b0;
        fix_aw     = 0;
        fix_dw     = 0;
        fix_rdata  = '0;
        cur.act    = 1'b0;
        cur.g      = 0;
        cur.aw     = 0;
        cur.dw     = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]    = 1'b0;
            p_addr[i]  = '0;
            p_wdata[i] = '0;
            p_write[i] = 1'b0;
        end
        apply_reset();

        // Zero-wait read from requester 0.
        fix_rdata = 32'hDEADBEEF;
        new_req(0, 32'h100, 1'b0, 32'h0);
        run_xfer();

        // Write from requester 1 with two data-phase wait states.
        fix_dw = 2;
        new_req(1, 32'h20, 1'b1, 32'h12345678);
        run_xfer();

        // Both requesters hold req_valid: grants must alternate starting at 0.
        fix_dw = 0;
        grant_log.delete();
        mode = GEN_HOLD;
        for (int g = 0; g < 60 && grant_log.size() < 4; g++) step();
        drain();
        check("hold_grants", grant_log.size() >= 4, 1'b1);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            check("rr_order", grant_log[k], k % 2);
        end

        // Two-cycle ERROR on a read, then a normal transfer.
        fix_dw    = 1;
        fix_err   = 1'b1;
        fix_rdata = $urandom;
        new_req(0, 32'h400, 1'b0, 32'h0);
        run_xfer();
        fix_err   = 1'b0;
        fix_dw    = 0;
        new_req(1, 32'h404, 1'b0, 32'h0);
        run_xfer();

        // Address phase stretched by three not-ready cycles.
        fix_aw = 3;
        new_req(1, 32'hABC0, 1'b1, 32'hCAFEF00D);
        run_xfer();

        // Reset while the slave is stalling the data phase.
        fix_aw = 0;
        fix_dw = 6;
        new_req(0, 32'h800, 1'b0, 32'h0);
        repeat (4) step();
        new_req(0, 32'h900, 1'b0, 32'h0);
        new_req(1, 32'h904, 1'b1, 32'h5A5A5A5A);
        apply_reset();
        fix_dw = 0;
        grant_log.delete();
        run_xfer();
        run_xfer();
        check("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // Randomised traffic with a reset in the middle.
        use_fix = 1'b0;
        mode    = GEN_RANDOM;
        repeat (1500) step();
        apply_reset();
        repeat (1500) step();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
